// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and address constants for the fetch sequencer
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_e;
  localparam logic [31:0] FETCH_INC = 32'd4;
  localparam logic [31:0] ALIGN_MASK = ~32'h3;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
endpackage

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: next-PC priority mux (trap > redirect > sequential > hold) with alignment and misalign detect
//   pc/seq_pc       current PC / PC of the instruction just returned
//   trap/trap_vec   trap request and target
//   redirect/_addr  branch request and target
//   inc             advance to seq_pc + 4
//   pc_nxt          selected next PC, word aligned on flush
//   flush           trap or redirect this cycle
//   misalign        redirect (not overridden by trap) with nonzero low bits
module fetch_pc_next import fetch_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] seq_pc,
  input  logic              trap,
  input  logic [ADDR_W-1:0] trap_vec,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc_nxt,
  output logic              flush,
  output logic              misalign
);
  localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'(~ALIGN_MASK);
  assign flush = trap | redirect;
  assign misalign = redirect & ~trap & (redirect_addr[1:0] != 2'b00);
  assign pc_nxt = trap ? (trap_vec & MASK) :
                  redirect ? (redirect_addr & MASK) :
                  inc ? seq_pc + ADDR_W'(FETCH_INC) : pc;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the PC, one outstanding imem request, valid/ready output slot
//   clk_sys_i/rst_sys_i           clock, async active-high reset
//   boot_en_i                     leave IDLE and start fetching
//   trap_i/trap_vec_i             trap flush and target (highest priority)
//   redirect_i/redirect_addr_i    branch flush and target
//   imem_req_o/imem_addr_o        request port, held until imem_gnt_i
//   imem_rvalid_i/imem_rdata_i    response port
//   inst_valid_o/inst_o/inst_pc_o decode slot, handshaked with inst_ready_i
//   pc_o                          current fetch PC
//   misalign_o                    one-cycle pulse for a misaligned redirect target
module fetch_ctrl import fetch_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEFAULT_RESET_VEC)
) (
  input  logic              clk_sys_i,
  input  logic              rst_sys_i,
  input  logic              boot_en_i,
  input  logic              trap_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              misalign_o
);
  fetch_state_e state;
  logic [ADDR_W-1:0] pc, issued_pc, pc_nxt;
  logic [31:0] pend_inst;
  logic kill, flush, misalign, take, deliver, slot_free;
  assign take = state == WAIT && imem_rvalid_i;
  assign deliver = take && !kill && !flush;
  assign slot_free = !inst_valid_o || inst_ready_i;
  assign pc_o = pc;
  assign imem_addr_o = pc;
  fetch_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc(pc),
    .seq_pc(issued_pc),
    .trap(trap_i),
    .trap_vec(trap_vec_i),
    .redirect(redirect_i),
    .redirect_addr(redirect_addr_i),
    .inc(deliver),
    .pc_nxt(pc_nxt),
    .flush(flush),
    .misalign(misalign)
  );
  // A response arriving while the slot is still occupied is parked in pend_inst
  // (its PC is still issued_pc) and moved into the slot when decode drains it.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state <= IDLE;
      pc <= RESET_VEC;
      issued_pc <= RESET_VEC;
      kill <= 1'b0;
      pend_inst <= 32'h0;
      imem_req_o <= 1'b0;
      inst_valid_o <= 1'b0;
      inst_o <= 32'h0;
      inst_pc_o <= RESET_VEC;
      misalign_o <= 1'b0;
    end else begin
      pc <= pc_nxt;
      misalign_o <= misalign;
      if (flush || (inst_valid_o && inst_ready_i)) inst_valid_o <= 1'b0;
      case (state)
        IDLE: if (boot_en_i && !flush) begin
          state <= REQ;
          imem_req_o <= 1'b1;
        end
        REQ: if (imem_gnt_i) begin
          state <= WAIT;
          imem_req_o <= 1'b0;
          issued_pc <= pc;
          kill <= flush;
        end
        WAIT: if (take) begin
          kill <= 1'b0;
          state <= (deliver && !slot_free) ? HOLD : REQ;
          imem_req_o <= !(deliver && !slot_free);
          pend_inst <= imem_rdata_i;
          if (deliver && slot_free) begin
            inst_valid_o <= 1'b1;
            inst_o <= imem_rdata_i;
            inst_pc_o <= issued_pc;
          end
        end else if (flush) kill <= 1'b1;
        HOLD: if (flush || inst_ready_i) begin
          state <= REQ;
          imem_req_o <= 1'b1;
          if (!flush) begin
            inst_valid_o <= 1'b1;
            inst_o <= pend_inst;
            inst_pc_o <= issued_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: vector table, directed sequences and randomized stream model for fetch_ctrl
module tb_fetch_ctrl;
  logic clk = 1'b0, rst = 1'b1, boot_en = 1'b0, trap = 1'b0, redirect = 1'b0;
  logic gnt = 1'b0, rvalid = 1'b0, ready = 1'b0;
  logic [31:0] trap_vec = 32'h0, redirect_addr = 32'h0, rdata = 32'h0;
  logic imem_req, inst_valid, misalign;
  logic [31:0] imem_addr, inst, inst_pc, pc;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  fetch_ctrl dut (
    .clk_sys_i(clk), .rst_sys_i(rst), .boot_en_i(boot_en),
    .trap_i(trap), .trap_vec_i(trap_vec), .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .inst_valid_o(inst_valid), .inst_o(inst), .inst_pc_o(inst_pc), .inst_ready_i(ready),
    .pc_o(pc), .misalign_o(misalign)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0013;
  endfunction
  typedef struct {
    logic t;
    logic [31:0] tv;
    logic r;
    logic [31:0] ra;
    logic [31:0] pc;
    logic mis;
  } vec_t;
  vec_t vt[8];
  logic [31:0] exp_pc, paddr;
  logic exp_mis, pend;
  int cnt, ntx;
  initial begin
    vt[0] = '{1'b1, 32'h200, 1'b1, 32'h300, 32'h200, 1'b0};
    vt[1] = '{1'b0, 32'h0, 1'b1, 32'h102, 32'h100, 1'b1};
    vt[2] = '{1'b1, 32'h2003, 1'b0, 32'h0, 32'h2000, 1'b0};
    vt[3] = '{1'b1, 32'h41, 1'b1, 32'h43, 32'h40, 1'b0};
    vt[4] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h40, 1'b0};
    vt[5] = '{1'b0, 32'h0, 1'b1, 32'h1000, 32'h1000, 1'b0};
    vt[6] = '{1'b0, 32'h0, 1'b1, 32'hffff_ffff, 32'hffff_fffc, 1'b1};
    vt[7] = '{1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_mis", misalign, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      trap = vt[i].t; trap_vec = vt[i].tv; redirect = vt[i].r; redirect_addr = vt[i].ra;
      @(negedge clk);
      trap = 1'b0; redirect = 1'b0;
      chk($sformatf("vec%0d_pc", i), pc, vt[i].pc);
      chk($sformatf("vec%0d_mis", i), misalign, vt[i].mis);
      chk($sformatf("vec%0d_idle_req", i), imem_req, 1'b0);
    end
    boot_en = 1'b1; gnt = 1'b1; ready = 1'b1;
    @(negedge clk);
    chk("boot_req", imem_req, 1'b1);
    chk("boot_addr0", imem_addr, 32'h0);
    @(negedge clk);
    chk("boot_wait_req", imem_req, 1'b0);
    rvalid = 1'b1; rdata = 32'h13;
    @(negedge clk);
    rvalid = 1'b0;
    chk("boot_valid", inst_valid, 1'b1);
    chk("boot_inst_pc0", inst_pc, 32'h0);
    chk("boot_inst0", inst, 32'h13);
    chk("boot_addr4", imem_addr, 32'h4);
    @(negedge clk);
    chk("boot_consumed", inst_valid, 1'b0);
    rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    chk("boot_inst_pc4", inst_pc, 32'h4);
    chk("boot_inst4", inst, 32'h13);
    chk("boot_addr8", imem_addr, 32'h8);
    ready = 1'b0;
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'habcd;
    @(negedge clk);
    rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", inst_valid, 1'b1);
      chk("hold_inst_pc", inst_pc, 32'h4);
      chk("hold_inst", inst, 32'h13);
      chk("hold_no_req", imem_req, 1'b0);
      if (i == 3) ready = 1'b1;
      @(negedge clk);
    end
    chk("drain_inst_pc", inst_pc, 32'h8);
    chk("drain_inst", inst, 32'habcd);
    chk("drain_req", imem_req, 1'b1);
    chk("drain_addr", imem_addr, 32'hc);
    @(negedge clk);
    chk("redir_pre_valid", inst_valid, 1'b0);
    redirect = 1'b1; redirect_addr = 32'h100;
    @(negedge clk);
    redirect = 1'b0; rvalid = 1'b1; rdata = 32'hdead;
    @(negedge clk);
    rvalid = 1'b0;
    chk("stale_dropped", inst_valid, 1'b0);
    chk("redir_req", imem_req, 1'b1);
    chk("redir_addr", imem_addr, 32'h100);
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'h1111;
    @(negedge clk);
    rvalid = 1'b0;
    chk("redir_inst_pc", inst_pc, 32'h100);
    chk("redir_inst", inst, 32'h1111);
    @(negedge clk);
    trap = 1'b1; trap_vec = 32'h200; redirect = 1'b1; redirect_addr = 32'h301;
    @(negedge clk);
    trap = 1'b0; redirect = 1'b0;
    chk("both_mis", misalign, 1'b0);
    chk("both_pc", pc, 32'h200);
    rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    chk("both_req", imem_req, 1'b1);
    chk("both_addr", imem_addr, 32'h200);
    @(negedge clk);
    redirect = 1'b1; redirect_addr = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
    chk("mis_pc", pc, 32'h100);
    chk("mis_pulse", misalign, 1'b1);
    rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    chk("mis_drop", misalign, 1'b0);
    chk("mis_addr", imem_addr, 32'h100);
    redirect = 1'b1; redirect_addr = 32'hffff_fffc;
    @(negedge clk);
    redirect = 1'b0; rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    chk("wrap_addr_hi", imem_addr, 32'hffff_fffc);
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'h77;
    @(negedge clk);
    rvalid = 1'b0;
    chk("wrap_inst_pc", inst_pc, 32'hffff_fffc);
    chk("wrap_inst", inst, 32'h77);
    chk("wrap_addr0", imem_addr, 32'h0);
    ready = 1'b0;
    @(negedge clk);
    boot_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_req", imem_req, 1'b0);
    chk("arst_valid", inst_valid, 1'b0);
    chk("arst_inst", inst, 32'h0);
    chk("arst_inst_pc", inst_pc, 32'h0);
    chk("arst_pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b0; rvalid = 1'b1; rdata = 32'h99;
    @(negedge clk);
    rvalid = 1'b0;
    chk("late_rvalid_valid", inst_valid, 1'b0);
    chk("late_rvalid_req", imem_req, 1'b0);
    @(negedge clk);
    chk("idle_stays", imem_req, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; boot_en = 1'b1;
    exp_pc = 32'h0; exp_mis = 1'b0; pend = 1'b0; cnt = 0; ntx = 0; paddr = 32'h0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      chk("rnd_mis", misalign, exp_mis);
      trap = $urandom_range(0, 63) == 0;
      redirect = $urandom_range(0, 23) == 0;
      trap_vec = $urandom_range(0, 4095);
      redirect_addr = $urandom_range(0, 7) == 0 ? (32'hffff_fff0 | $urandom_range(0, 15)) : $urandom_range(0, 4095);
      ready = $urandom_range(0, 3) != 0;
      gnt = imem_req && $urandom_range(0, 2) != 0;
      if (pend && cnt == 0) begin
        rvalid = 1'b1; rdata = memfn(paddr); pend = 1'b0;
      end else begin
        rvalid = 1'b0; cnt--;
      end
      if (imem_req && gnt) begin
        pend = 1'b1; paddr = imem_addr; cnt = $urandom_range(0, 4);
      end
      if (imem_req) chk("rnd_addr_align", imem_addr[1:0], 2'b00);
      if (inst_valid && ready && !(trap || redirect)) begin
        chk("rnd_inst_pc", inst_pc, exp_pc);
        chk("rnd_inst", inst, memfn(exp_pc));
        exp_pc = exp_pc + 32'd4;
        ntx++;
      end
      if (trap || redirect) exp_pc = (trap ? trap_vec : redirect_addr) & ~32'h3;
      exp_mis = redirect && !trap && redirect_addr[1:0] != 2'b00;
    end
    chk("rnd_progress", ntx > 100, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
